audio_dsm: RTL and testbench

- Audio back end between the console core's signed 9-bit PCM output and the board's 1-bit AUDIO_L/AUDIO_R pins.
- Latches PCM on a sample strobe and scales it to signed 16-bit, which also feeds I2S.
- Applies a click-free soft-mute ramp, then drives a second-order sigma-delta modulator at the full system clock rate, one bitstream on both pins.

---
 rtl/audio_dsm.sv | 128 ++++++++++++
 tb/tb_audio_dsm.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dsm.sv
// Audio back end: latches signed PCM, scales it to 16 bits for I2S, applies a soft-mute
// volume ramp and drives a second-order sigma-delta bitstream onto both DAC pins.
module audio_dsm #(
  parameter int IN_W      = 9,
  parameter int ACC_W     = 20,
  parameter int RAMP_LOG2 = 10
) (
  input  logic                   CLK,
  input  logic                   RESB,
  input  logic                   PCM_CE,
  input  logic signed [IN_W-1:0] PCM,
  input  logic [1:0]             SHIFT,
  input  logic                   MUTE,
  output logic signed [15:0]     PCM16,
  output logic                   PCM16_VALID,
  output logic                   DAC_L,
  output logic                   DAC_R
);

  localparam int SUM_W = ACC_W + 2;
  localparam logic [4:0] VOL_MAX = 5'd16;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((longint'(1) <<< (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI;
  localparam logic signed [SUM_W-1:0] FB_POS = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] FB_NEG = SUM_W'(-32768);

  // Symmetric clamp keeps the integrators from ever wrapping.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
    if (v > SAT_HI) begin
      return SAT_HI[ACC_W-1:0];
    end else if (v < SAT_LO) begin
      return SAT_LO[ACC_W-1:0];
    end else begin
      return v[ACC_W-1:0];
    end
  endfunction

  logic signed [15:0]      pcm16_q, pcm16_d;
  logic                    valid_q, valid_d;
  logic [RAMP_LOG2-1:0]    ramp_q, ramp_d;
  logic [4:0]              vol_q, vol_d;
  logic signed [ACC_W-1:0] i1_q, i1_d;
  logic signed [ACC_W-1:0] i2_q, i2_d;
  logic                    dac_q, dac_r_q, dac_d;

  logic signed [15:0]      pcm_sx;
  logic signed [15:0]      pcm_ext;
  logic                    wrap;
  logic signed [5:0]       vol_s;
  logic signed [21:0]      prod;
  logic signed [20:0]      prod21;
  logic signed [20:0]      prod_shr;
  logic signed [15:0]      x;
  logic signed [SUM_W-1:0] fb;
  logic signed [SUM_W-1:0] i1_sum;
  logic signed [SUM_W-1:0] i2_sum;

  // Capture stage: left-justify the sample into 16 bits, then attenuate.
  assign pcm_sx  = 16'(PCM);
  assign pcm_ext = pcm_sx <<< (16 - IN_W);

  always_comb begin
    pcm16_d = pcm16_q;
    valid_d = 1'b0;
    if (PCM_CE) begin
      pcm16_d = pcm_ext >>> SHIFT;
      valid_d = 1'b1;
    end
  end

  // Volume ramp: one step per counter wrap, direction follows MUTE at that edge.
  assign wrap   = &ramp_q;
  assign ramp_d = ramp_q + RAMP_LOG2'(1);

  always_comb begin
    vol_d = vol_q;
    if (wrap) begin
      if (MUTE && (vol_q != 5'd0)) begin
        vol_d = vol_q - 5'd1;
      end else if (!MUTE && (vol_q < VOL_MAX)) begin
        vol_d = vol_q + 5'd1;
      end
    end
  end

  // Gain stage: vol is 0..16 in units of 1/16, so 16 reproduces PCM16 exactly.
  assign vol_s    = {1'b0, vol_q};
  assign prod     = pcm16_q * vol_s;
  assign prod21   = prod[20:0];
  assign prod_shr = prod21 >>> 4;
  assign x        = prod_shr[15:0];

  // Modulator stage: two cascaded integrators sharing a single 1-bit feedback.
  assign fb     = dac_q ? FB_POS : FB_NEG;
  assign i1_sum = SUM_W'(i1_q) + SUM_W'(x) - fb;
  assign i1_d   = sat_acc(i1_sum);
  assign i2_sum = SUM_W'(i2_q) + SUM_W'(i1_d) - fb;
  assign i2_d   = sat_acc(i2_sum);
  assign dac_d  = ~i2_d[ACC_W-1];

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      pcm16_q <= '0;
      valid_q <= 1'b0;
      ramp_q  <= '0;
      vol_q   <= VOL_MAX;
      i1_q    <= '0;
      i2_q    <= '0;
      dac_q   <= 1'b0;
      dac_r_q <= 1'b0;
    end else begin
      pcm16_q <= pcm16_d;
      valid_q <= valid_d;
      ramp_q  <= ramp_d;
      vol_q   <= vol_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      dac_q   <= dac_d;
      dac_r_q <= dac_d;
    end
  end

  assign PCM16       = pcm16_q;
  assign PCM16_VALID = valid_q;
  assign DAC_L       = dac_q;
  assign DAC_R       = dac_r_q;

endmodule

// File: tb/tb_audio_dsm.sv
// Bench for audio_dsm: capture vector table with a PCM16 scoreboard, a cycle model of the
// volume ramp and modulator, density windows, ramp timing and asynchronous reset sequences.
module tb_audio_dsm;

  logic              CLK = 1'b0;
  logic              RESB = 1'b1;
  logic              PCM_CE;
  logic signed [8:0] PCM;
  logic [1:0]        SHIFT;
  logic              MUTE;
  logic signed [15:0] PCM16;
  logic              PCM16_VALID;
  logic              DAC_L;
  logic              DAC_R;

  audio_dsm #(.IN_W(9), .ACC_W(20), .RAMP_LOG2(10)) dut (
    .CLK(CLK), .RESB(RESB), .PCM_CE(PCM_CE), .PCM(PCM), .SHIFT(SHIFT), .MUTE(MUTE),
    .PCM16(PCM16), .PCM16_VALID(PCM16_VALID), .DAC_L(DAC_L), .DAC_R(DAC_R)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic signed [15:0] m_pcm16 = '0;
  logic               m_vld = 1'b0;
  int                 m_vol = 16;
  int                 m_cnt = 0;
  longint             m_i1 = 0;
  longint             m_i2 = 0;
  logic               m_dac = 1'b0;
  longint             mx, mfb, ma, mb;

  function automatic longint msat(input longint v);
    if (v > 524287) return 524287;
    if (v < -524287) return -524287;
    return v;
  endfunction

  always @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      m_pcm16 <= '0;
      m_vld   <= 1'b0;
      m_vol   <= 16;
      m_cnt   <= 0;
      m_i1    <= 0;
      m_i2    <= 0;
      m_dac   <= 1'b0;
    end else begin
      mx  = (longint'(m_pcm16) * m_vol) >>> 4;
      mfb = m_dac ? 32767 : -32768;
      ma  = msat(m_i1 + mx - mfb);
      mb  = msat(m_i2 + ma - mfb);
      m_i1  <= ma;
      m_i2  <= mb;
      m_dac <= (mb >= 0);
      if (PCM_CE) begin
        m_pcm16 <= 16'((longint'(PCM) * 128) >>> SHIFT);
        m_vld   <= 1'b1;
      end else begin
        m_vld <= 1'b0;
      end
      if (m_cnt == 1023) begin
        if (MUTE && m_vol > 0) m_vol <= m_vol - 1;
        else if (!MUTE && m_vol < 16) m_vol <= m_vol + 1;
      end
      m_cnt <= (m_cnt + 1) % 1024;
    end
  end

  logic signed [15:0] sb[$];
  int trk_bad = 0;
  int wrap_bad = 0;
  int ones = 0;
  bit dens_en = 1'b0;
  bit vol_watch = 1'b0;
  int vol_up = 0;
  int last_vol = 16;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic tick();
    logic signed [15:0] e;
    @(posedge CLK);
    @(negedge CLK);
    if (DAC_L !== m_dac || DAC_R !== DAC_L || PCM16 !== m_pcm16 || PCM16_VALID !== m_vld ||
        longint'(dut.i1_q) != m_i1 || longint'(dut.i2_q) != m_i2 || int'(dut.vol_q) != m_vol)
      trk_bad++;
    if (longint'(dut.i1_q) == -524288 || longint'(dut.i2_q) == -524288) wrap_bad++;
    if (dens_en) ones += int'(DAC_L);
    if (vol_watch && int'(dut.vol_q) > last_vol) vol_up++;
    last_vol = int'(dut.vol_q);
    if (PCM16_VALID) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_pcm16", longint'(PCM16), longint'(e));
      end
    end
  endtask

  task automatic density(input int n);
    ones = 0;
    dens_en = 1'b1;
    repeat (n) tick();
    dens_en = 1'b0;
  endtask

  task automatic strobe(input logic [8:0] p, input logic [1:0] s, input logic signed [15:0] e);
    PCM = p;
    SHIFT = s;
    PCM_CE = 1'b1;
    sb.push_back(e);
    tick();
    PCM_CE = 1'b0;
  endtask

  typedef struct {
    logic [8:0]         pcm;
    logic [1:0]         shift;
    logic signed [15:0] exp;
  } vec_t;

  vec_t tbl[8];
  int   trk0;
  int   wrap0;
  int   guard;

  initial begin
    tbl[0] = '{9'h07F, 2'd0, 16'sh3F80};
    tbl[1] = '{9'h07F, 2'd2, 16'sh0FE0};
    tbl[2] = '{9'h100, 2'd0, 16'sh8000};
    tbl[3] = '{9'h0FF, 2'd0, 16'sh7F80};
    tbl[4] = '{9'h1FF, 2'd3, 16'shFFF0};
    tbl[5] = '{9'h100, 2'd1, 16'shC000};
    tbl[6] = '{9'h055, 2'd1, 16'sh1540};
    tbl[7] = '{9'h180, 2'd3, 16'shF800};

    PCM = '0;
    SHIFT = 2'd0;
    PCM_CE = 1'b0;
    MUTE = 1'b0;
    #2 RESB = 1'b0;
    #2;
    chk("rst_pcm16", longint'(PCM16), 0);
    chk("rst_valid", longint'(PCM16_VALID), 0);
    chk("rst_dac_l", longint'(DAC_L), 0);
    chk("rst_dac_r", longint'(DAC_R), 0);
    chk("rst_vol", longint'(dut.vol_q), 16);
    @(negedge CLK);
    RESB = 1'b1;

    // Idle: zero input settles to a 50% bitstream.
    trk0 = trk_bad;
    repeat (64) tick();
    density(4096);
    chk_rng("idle_density", ones, 2028, 2068);
    chk("idle_track", trk_bad - trk0, 0);

    // Capture table.
    trk0 = trk_bad;
    for (int i = 0; i < 8; i++) begin
      strobe(tbl[i].pcm, tbl[i].shift, tbl[i].exp);
      chk("cap_pcm16", longint'(PCM16), longint'(tbl[i].exp));
      chk("cap_valid", longint'(PCM16_VALID), 1);
      PCM = ~tbl[i].pcm;
      SHIFT = ~tbl[i].shift;
      tick();
      chk("cap_valid_drop", longint'(PCM16_VALID), 0);
      chk("cap_hold", longint'(PCM16), longint'(tbl[i].exp));
    end
    // Back-to-back strobes.
    PCM = 9'h001; SHIFT = 2'd0; PCM_CE = 1'b1; sb.push_back(16'sh0080); tick();
    PCM = 9'h1FF; SHIFT = 2'd0;                sb.push_back(16'shFF80); tick();
    PCM = 9'h100; SHIFT = 2'd3;                sb.push_back(16'shF000); tick();
    PCM_CE = 1'b0;
    tick();
    chk("b2b_last", longint'(PCM16), -4096);
    chk("b2b_drain", sb.size(), 0);
    chk("cap_track", trk_bad - trk0, 0);

    // Full-scale negative then positive.
    trk0 = trk_bad;
    wrap0 = wrap_bad;
    strobe(9'h100, 2'd0, 16'sh8000);
    repeat (64) tick();
    density(4096);
    chk_rng("neg_fs_density", ones, 0, 20);
    chk("neg_fs_nowrap", wrap_bad - wrap0, 0);
    strobe(9'h0FF, 2'd0, 16'sh7F80);
    repeat (64) tick();
    density(4096);
    chk_rng("pos_fs_density", ones, 4056, 4096);
    chk("fs_track", trk_bad - trk0, 0);

    // Soft mute of a half-scale tone.
    trk0 = trk_bad;
    strobe(9'h080, 2'd0, 16'sh4000);
    repeat (64) tick();
    density(4096);
    chk_rng("unmuted_density", ones, 3052, 3092);
    chk("pre_mute_vol", longint'(dut.vol_q), 16);
    MUTE = 1'b1;
    vol_up = 0;
    last_vol = int'(dut.vol_q);
    vol_watch = 1'b1;
    repeat (16384) tick();
    vol_watch = 1'b0;
    chk("mute_vol0", longint'(dut.vol_q), 0);
    chk("mute_monotonic", vol_up, 0);
    density(4096);
    chk_rng("muted_density", ones, 2028, 2068);
    MUTE = 1'b0;
    guard = 0;
    while (m_vol != 16 && guard < 17 * 1024) begin tick(); guard++; end
    chk("unmute_reach16", longint'(dut.vol_q), 16);
    MUTE = 1'b1;
    guard = 0;
    while (m_vol != 8 && guard < 9 * 1024) begin tick(); guard++; end
    chk("mute_reach8", longint'(dut.vol_q), 8);
    MUTE = 1'b0;
    repeat (8191) tick();
    chk("reverse_vol15", longint'(dut.vol_q), 15);
    tick();
    chk("reverse_vol16", longint'(dut.vol_q), 16);
    chk("mute_track", trk_bad - trk0, 0);

    // Strobe landing on the ramp wrap edge while muting.
    trk0 = trk_bad;
    MUTE = 1'b1;
    guard = 0;
    while (m_cnt != 1023 && guard < 1100) begin tick(); guard++; end
    chk("wrap_found", m_cnt, 1023);
    strobe(9'h0AA, 2'd0, 16'sh5500);
    chk("coinc_pcm16", longint'(PCM16), 16'sh5500);
    chk("coinc_valid", longint'(PCM16_VALID), 1);
    chk("coinc_vol", longint'(dut.vol_q), 15);
    repeat (300) tick();
    chk("coinc_track", trk_bad - trk0, 0);

    // Asynchronous reset mid-ramp.
    chk("pre_rst_i2_busy", longint'(dut.i2_q != 0), 1);
    #2 RESB = 1'b0;
    #1;
    chk("arst_pcm16", longint'(PCM16), 0);
    chk("arst_valid", longint'(PCM16_VALID), 0);
    chk("arst_dac_l", longint'(DAC_L), 0);
    chk("arst_dac_r", longint'(DAC_R), 0);
    chk("arst_vol", longint'(dut.vol_q), 16);
    chk("arst_i1", longint'(dut.i1_q), 0);
    chk("arst_i2", longint'(dut.i2_q), 0);
    chk("arst_ramp", longint'(dut.ramp_q), 0);
    @(negedge CLK);
    RESB = 1'b1;
    MUTE = 1'b0;
    trk0 = trk_bad;
    repeat (100) tick();
    chk("post_rst_pcm16", longint'(PCM16), 0);
    chk("post_rst_track", trk_bad - trk0, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
